// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start detection, 3-sample majority vote per bit,
// LSB-first data shift, optional even/odd parity and stop-bit checking.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] SMP0     = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] SMP1     = CNT_W'(PRESCALE / 2);
    localparam logic [CNT_W-1:0] SMP2     = CNT_W'(PRESCALE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [1:0]            samp_q,       samp_d;
    logic                  vote_q,       vote_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic                  par_en_q,     par_en_d;
    logic                  par_typ_q,    par_typ_d;
    logic                  par_bad_q,    par_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q,    par_err_d;
    logic                  stp_err_q,    stp_err_d;
    logic                  busy_q,       busy_d;

    logic vote_c;
    logic vote_now_c;

    // Majority of the two stored samples and the live line (valid at the third sample point)
    always_comb begin
        vote_c     = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);
        vote_now_c = (cnt_q == SMP2) ? vote_c : vote_q;
    end

    // Next-state, sampling, shifting and output pulse generation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        vote_d       = vote_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (cnt_q == SMP0) samp_d[0] = RX_IN;
        if (cnt_q == SMP1) samp_d[1] = RX_IN;
        if (cnt_q == SMP2) vote_d    = vote_c;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!RX_IN) begin
                    state_d   = START;
                    cnt_d     = CNT_W'(1);
                    bit_cnt_d = '0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = vote_now_c ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == SMP2) shift_d = {vote_c, shift_q[DATA_WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt_q == SMP2) par_bad_d = (vote_c != ((^shift_q) ^ par_typ_q));
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == SMP2) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    if (vote_c) begin
                        if (par_bad_q) begin
                            par_err_d = 1'b1;
                        end else begin
                            data_valid_d = 1'b1;
                            p_data_d     = shift_q;
                        end
                    end else begin
                        stp_err_d = 1'b1;
                        par_err_d = par_bad_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            vote_q       <= 1'b0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            vote_q       <= vote_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frames are driven bit by bit, expected
// completions are queued at drive time and matched against DUT pulses.
module tb_uart_rx_fsm;

    localparam int unsigned DW = 8;
    localparam int unsigned PS = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            cyc;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] pd;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_pdata = '0;
    int            busy_lo = 0;
    int            busy_hi = -1;
    logic          bchk_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse scoreboard and per-cycle busy window check
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (data_valid || par_err || stp_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({data_valid, par_err, stp_err}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("data_valid",  32'(data_valid), 32'(e.dv));
                check("par_err",     32'(par_err),    32'(e.pe));
                check("stp_err",     32'(stp_err),    32'(e.se));
                check("P_DATA",      32'(P_DATA),     32'(e.pd));
            end
        end
        if (!RST && bchk_en)
            check("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
    end

    task automatic drive_bit(input logic v, input int gcnt);
        for (int c = 0; c < int'(PS); c++) begin
            RX_IN = (c == gcnt) ? ~v : v;
            @(posedge CLK); #1;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stop,
                              input int gbit, input int gcnt);
        int   start;
        int   last;
        logic bad;
        exp_t e;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        start   = cyc;
        last    = pen ? 85 : 77;
        busy_lo = start + 1;
        busy_hi = start + last;
        bad     = pen && (pbit != ((^d) ^ ptyp));
        e.cyc   = start + last + 1;
        e.dv    = stop && !bad;
        e.pe    = bad;
        e.se    = !stop;
        if (e.dv) exp_pdata = d;
        e.pd    = exp_pdata;
        sb.push_back(e);
        drive_bit(1'b0, -1);
        PAR_EN  = ~pen;
        PAR_TYP = ~ptyp;
        for (int i = 0; i < int'(DW); i++) drive_bit(d[i], (i == gbit) ? gcnt : -1);
        if (pen) drive_bit(pbit, -1);
        drive_bit(stop, -1);
        PAR_EN  = pen;
        PAR_TYP = ptyp;
    endtask

    initial begin
        int start;

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_P_DATA", 32'(P_DATA), 32'd0);
        check("rst_flags",  32'({data_valid, par_err, stp_err, busy}), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(4);
        bchk_en = 1'b1;

        // good frame without parity
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);

        // parity: even ok, even bad, odd ok
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        idle(4);

        // stop error; the held-low line looks like a new start, so skip busy checks
        bchk_en = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(20);
        bchk_en = 1'b1;

        // start glitch, then a good frame
        start   = cyc;
        busy_lo = start + 1;
        busy_hi = start + 7;
        RX_IN = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        idle(14);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);

        // back-to-back frames, second with one corrupted sample in data bit 2
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3);
        idle(4);

        // reset during data bit 4
        bchk_en = 1'b0;
        drive_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
        repeat (3) begin @(posedge CLK); #1; end
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        exp_pdata = '0;
        check("midrst_busy",   32'(busy), 32'd0);
        check("midrst_P_DATA", 32'(P_DATA), 32'd0);
        check("midrst_flags",  32'({data_valid, par_err, stp_err}), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(10);
        bchk_en = 1'b1;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge CLK);
        check("final_P_DATA", 32'(P_DATA), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
